regdst_hazard_ctrl: RTL
=======================

# regdst_hazard_ctrl

Issue-stage controller for the pipelined MIPS datapath. It computes the write-back destination register that the EX-stage RegDst 3-to-1 mux will produce (rt, rd, $31, or an alternate), drives that mux's select, and tracks in-flight destinations through EX/MEM/WB. From those in-flight destinations it stalls decode on read-after-write hazards. It sits between the decode stage and the ID/EX pipeline register.

## Interface
Parameters:
- NSTAGE, 3, number of tracked stages after issue (EX, MEM, WB); legal 2..6.

Ports:
- Clk  in  1  rising-edge clock
- ResetN  in  1  asynchronous, active-low reset
- IssueValid  in  1  decode stage presents an instruction
- IssueReady  out  1  instruction accepted this cycle (combinational)
- Rs, Rt, Rd  in  5 each  instruction register fields
- UsesRs, UsesRt  in  1 each  source operand actually read
- DstMode  in  2  0=Rt, 1=Rd, 2=$31 (link), 3=AltDst
- AltDst  in  5  alternate destination for DstMode 3
- RegWrite  in  1  instruction writes the register file
- IsLoad  in  1  instruction is a load
- Flush  in  1  kill all in-flight entries (branch/jump redirect)
- RegDstSel  out  2  registered select for the EX RegDst mux
- ExDst  out  5  destination of the instruction now in EX
- WbValid  out  1  a tracked write retires this cycle
- WbDst  out  5  register written by the retiring instruction
- StallCount  out  16  saturating count of stall cycles

## Operation
- Tracking pipeline: NSTAGE entries {valid, dst[4:0], load}. Entry 0 is EX; entry NSTAGE-1 is WB. All entries shift one position every cycle with no enable.
- Destination select: dst = Rt / Rd / 5'd31 / AltDst for DstMode 0/1/2/3.
- Accept (IssueValid && IssueReady): entry 0 loads {RegWrite && dst!=0, dst, IsLoad}. RegDstSel loads DstMode and ExDst loads dst.
- No accept: entry 0 loads a bubble (valid=0), RegDstSel <= 0, ExDst <= 0.
- Match on source s: UsesS && s!=0 && entry valid && entry.dst==s.
- hazard requires IssueValid plus a match, as defined in Configuration. IssueReady = !hazard.
- Flush (synchronous, highest priority): all entries invalid, RegDstSel and ExDst cleared, and nothing is accepted that edge. IssueReady is forced to 0 in the Flush cycle. StallCount is unchanged.
- WbValid and WbDst are taken combinationally from entry NSTAGE-1. WbDst = 0 when not valid.
- StallCount increments on every cycle with IssueValid && !IssueReady && !Flush, and saturates at 16'hFFFF.
- Register $0 is never tracked and never causes a stall.

## Timing
- Reset (ResetN low, asynchronous): all entries invalid, RegDstSel=0, ExDst=0, WbValid=0, WbDst=0, StallCount=0. IssueReady follows from the empty state (1).
- IssueReady has zero-cycle latency, combinational from inputs and state.
- Accepted instruction: visible on RegDstSel/ExDst 1 cycle after accept; WbValid NSTAGE cycles after accept.
- WB stage writes in the first half-cycle and reads in the second, so the entry in NSTAGE-1 never causes a stall.
- Stall: the consumer holds its fields stable while IssueReady=0. A bubble enters EX each stalled cycle.
- Simultaneous Flush and a hazard: Flush wins, and the stall clears the following cycle.
- Reset mid-stall: the stall drops immediately (asynchronous) and StallCount clears.

## Configuration
- Macro: REGDST_HAZARD_FORWARDING_EN.
- Defined: the datapath forwards from MEM and WB. hazard only on a match with entry 0 where load=1 (load-use), giving a 1-cycle stall.
- Undefined: no forwarding. hazard on a match with any valid entry 0..NSTAGE-2, giving up to NSTAGE-1 stall cycles.

## Test plan
1. Reset, accept add $3 (DstMode=1, Rd=3, RegWrite=1), next cycle present Rs=3, UsesRs=1:
   - forwarding defined -> IssueReady=1, StallCount=0.
   - forwarding undefined (NSTAGE=3) -> IssueReady=0 for 2 cycles, StallCount=2.
2. Forwarding defined: lw $5 (DstMode=0, Rt=5, IsLoad=1) then consumer Rt=5, UsesRt=1 -> exactly 1 stall cycle. RegDstSel=0 and ExDst=0 during the bubble.
3. jal (DstMode=2, RegWrite=1):
   - 1 cycle later -> RegDstSel=2, ExDst=31.
   - 3 cycles later -> WbValid=1, WbDst=31.
4. Producer writes $0 (Rd=0, RegWrite=1), consumer Rs=0 -> no stall, and WbValid stays 0 for that slot.
5. Load-use stall in progress, assert Flush for 1 cycle:
   - IssueReady=0 in the Flush cycle.
   - IssueReady=1 the next cycle, all entries invalid, WbValid=0 for NSTAGE cycles.
6. Force a persistent hazard for 70000 cycles -> StallCount holds at 16'hFFFF. Then pulse ResetN low mid-stall -> StallCount=0 and IssueReady=1 immediately.

Source files
------------

// File: rtl/regdst_hazard_ctrl_if.sv
// regdst_hazard_ctrl_if: decode/issue, RegDst select and write-back signal bundle.
interface regdst_hazard_ctrl_if;
  logic        IssueValid, IssueReady;
  logic [4:0]  Rs, Rt, Rd, AltDst;
  logic        UsesRs, UsesRt;
  logic [1:0]  DstMode;
  logic        RegWrite, IsLoad, Flush;
  logic [1:0]  RegDstSel;
  logic [4:0]  ExDst;
  logic        WbValid;
  logic [4:0]  WbDst;
  logic [15:0] StallCount;
  modport master (
    output IssueValid, Rs, Rt, Rd, AltDst, UsesRs, UsesRt, DstMode, RegWrite, IsLoad, Flush,
    input  IssueReady, RegDstSel, ExDst, WbValid, WbDst, StallCount
  );
  modport slave (
    input  IssueValid, Rs, Rt, Rd, AltDst, UsesRs, UsesRt, DstMode, RegWrite, IsLoad, Flush,
    output IssueReady, RegDstSel, ExDst, WbValid, WbDst, StallCount
  );
endinterface

// File: rtl/regdst_hazard_ctrl.sv
// regdst_hazard_ctrl: RegDst select, in-flight destination tracking and RAW stall control.
// REGDST_HAZARD_FORWARDING_EN: stall only on load-use against EX; otherwise stall on any EX..MEM match.
module regdst_hazard_ctrl #(
  parameter int NSTAGE = 3
) (
  input logic Clk,
  input logic ResetN,
  regdst_hazard_ctrl_if.slave bus
);
  logic [NSTAGE-1:0] vld_q, vld_d;
  logic [4:0]        dst_q [NSTAGE];
  logic [4:0]        dst_d [NSTAGE];
`ifdef REGDST_HAZARD_FORWARDING_EN
  logic [NSTAGE-1:0] ld_q, ld_d;
`endif
  logic [1:0]        sel_q, sel_d;
  logic [4:0]        exdst_q, exdst_d, dst;
  logic [15:0]       stall_q, stall_d;
  logic              hazard, accept;
  function automatic logic hit(input logic uses, input logic [4:0] s, input logic v, input logic [4:0] d);
    return uses && s != 5'd0 && v && d == s;
  endfunction
  always_comb begin
    dst = bus.DstMode == 2'd0 ? bus.Rt : bus.DstMode == 2'd1 ? bus.Rd : bus.DstMode == 2'd2 ? 5'd31 : bus.AltDst;
    hazard = 1'b0;
`ifdef REGDST_HAZARD_FORWARDING_EN
    hazard = ld_q[0] && (hit(bus.UsesRs, bus.Rs, vld_q[0], dst_q[0]) || hit(bus.UsesRt, bus.Rt, vld_q[0], dst_q[0]));
`else
    // WB writes before the read half-cycle, so the last entry never stalls
    for (int i = 0; i < NSTAGE - 1; i++)
      hazard = hazard || hit(bus.UsesRs, bus.Rs, vld_q[i], dst_q[i]) || hit(bus.UsesRt, bus.Rt, vld_q[i], dst_q[i]);
`endif
    hazard = hazard && bus.IssueValid;
    bus.IssueReady = !hazard && !bus.Flush;
    accept = bus.IssueValid && bus.IssueReady;
    vld_d = bus.Flush ? '0 : {vld_q[NSTAGE-2:0], accept && bus.RegWrite && dst != 5'd0};
`ifdef REGDST_HAZARD_FORWARDING_EN
    ld_d = {ld_q[NSTAGE-2:0], accept && bus.IsLoad};
`endif
    dst_d[0] = accept ? dst : 5'd0;
    for (int i = 1; i < NSTAGE; i++)
      dst_d[i] = dst_q[i-1];
    sel_d = accept ? bus.DstMode : 2'd0;
    exdst_d = accept ? dst : 5'd0;
    stall_d = (bus.IssueValid && !bus.IssueReady && !bus.Flush && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      vld_q <= '0;
      dst_q <= '{default: 5'd0};
`ifdef REGDST_HAZARD_FORWARDING_EN
      ld_q <= '0;
`endif
      sel_q <= 2'd0;
      exdst_q <= 5'd0;
      stall_q <= 16'd0;
    end else begin
      vld_q <= vld_d;
      dst_q <= dst_d;
`ifdef REGDST_HAZARD_FORWARDING_EN
      ld_q <= ld_d;
`endif
      sel_q <= sel_d;
      exdst_q <= exdst_d;
      stall_q <= stall_d;
    end
  end
  assign bus.RegDstSel = sel_q;
  assign bus.ExDst = exdst_q;
  assign bus.WbValid = vld_q[NSTAGE-1];
  assign bus.WbDst = vld_q[NSTAGE-1] ? dst_q[NSTAGE-1] : 5'd0;
  assign bus.StallCount = stall_q;
endmodule
